// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, single-outstanding imem request FSM, 1-entry fetch buffer, IF/ID register.
// Latency: response visible in IF/ID one edge after the response cycle (bypass) or when Stall_d drops (buffered).
// Backpressure: Stall_f/full buffer gate new requests; Stall_d holds IF/ID; redirect kills in-flight and buffered fetches.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall_f,
    input  logic        Stall_d,
    input  logic        Flush_d,
    input  logic        PCSrc_e,
    input  logic [31:0] PCTarget_e,
    output logic        ImemReq_valid,
    input  logic        ImemReq_ready,
    output logic [31:0] ImemAddr,
    input  logic        ImemResp_valid,
    input  logic [31:0] ImemResp_data,
    output logic [31:0] Instr_d,
    output logic [31:0] PC_d,
    output logic [31:0] PCPlus4_d,
    output logic        Valid_d,
    output logic        Imem_wait
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_ent_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    state_t      state, state_nxt;
    logic [31:0] pc_f, pc_f_nxt;
    logic [31:0] req_pc;
    logic        buf_vld;
    fetch_ent_t  buf_ent;
    ifid_t       ifid;

    logic        req_fire;
    logic        resp_hit;
    logic        bypass;
    logic        buf_wr;
    logic        ifid_kill;
    logic        ifid_from_buf;

    // Request is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        ImemReq_valid = rst_n && (state == ST_REQ) && !Stall_f && !buf_vld && !PCSrc_e;
        req_fire      = ImemReq_valid && ImemReq_ready;
        resp_hit      = (state == ST_WAIT) && ImemResp_valid && !PCSrc_e;
        bypass        = resp_hit && !Stall_d && !buf_vld;
        buf_wr        = resp_hit && !bypass;
        ifid_kill     = Flush_d || PCSrc_e;
        ifid_from_buf = !ifid_kill && !Stall_d && buf_vld;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_REQ: begin
                if (req_fire) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (ImemResp_valid)  state_nxt = ST_REQ;
                else if (PCSrc_e)    state_nxt = ST_DROP;
            end
            ST_DROP: begin
                if (ImemResp_valid) state_nxt = ST_REQ;
            end
            default: state_nxt = ST_REQ;
        endcase
    end

    always_comb begin
        pc_f_nxt = pc_f;
        if (PCSrc_e)       pc_f_nxt = PCTarget_e;
        else if (req_fire) pc_f_nxt = pc_f + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_REQ;
            pc_f   <= RESET_PC;
            req_pc <= 32'h0;
        end else begin
            state <= state_nxt;
            pc_f  <= pc_f_nxt;
            if (req_fire) req_pc <= pc_f;
        end
    end

    // A buffer write only happens in WAIT, and no request is issued while the
    // buffer is full, so write and drain never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_vld <= 1'b0;
            buf_ent <= '0;
        end else begin
            if (PCSrc_e)            buf_vld <= 1'b0;
            else if (buf_wr)        buf_vld <= 1'b1;
            else if (ifid_from_buf) buf_vld <= 1'b0;
            if (buf_wr) begin
                buf_ent.instr <= ImemResp_data;
                buf_ent.pc    <= req_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid.instr    <= NOP;
            ifid.pc       <= 32'h0;
            ifid.pc_plus4 <= 32'h0;
            ifid.valid    <= 1'b0;
        end else if (ifid_kill) begin
            ifid.instr <= NOP;
            ifid.valid <= 1'b0;
        end else if (!Stall_d) begin
            if (ifid_from_buf) begin
                ifid.instr    <= buf_ent.instr;
                ifid.pc       <= buf_ent.pc;
                ifid.pc_plus4 <= buf_ent.pc + 32'd4;
                ifid.valid    <= 1'b1;
            end else if (bypass) begin
                ifid.instr    <= ImemResp_data;
                ifid.pc       <= req_pc;
                ifid.pc_plus4 <= req_pc + 32'd4;
                ifid.valid    <= 1'b1;
            end else begin
                ifid.instr <= NOP;
                ifid.valid <= 1'b0;
            end
        end
    end

    assign ImemAddr  = pc_f;
    assign Imem_wait = (state != ST_REQ);
    assign Instr_d   = ifid.instr;
    assign PC_d      = ifid.pc;
    assign PCPlus4_d = ifid.pc_plus4;
    assign Valid_d   = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a memory model plus a fetch-stream reference model feed
// expectation queues; a monitor compares DUT outputs against them every cycle.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        Stall_f, Stall_d, Flush_d, PCSrc_e;
    logic [31:0] PCTarget_e;
    logic        ImemReq_valid, ImemReq_ready;
    logic [31:0] ImemAddr;
    logic        ImemResp_valid;
    logic [31:0] ImemResp_data;
    logic [31:0] Instr_d, PC_d, PCPlus4_d;
    logic        Valid_d, Imem_wait;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Stall_f       (Stall_f),
        .Stall_d       (Stall_d),
        .Flush_d       (Flush_d),
        .PCSrc_e       (PCSrc_e),
        .PCTarget_e    (PCTarget_e),
        .ImemReq_valid (ImemReq_valid),
        .ImemReq_ready (ImemReq_ready),
        .ImemAddr      (ImemAddr),
        .ImemResp_valid(ImemResp_valid),
        .ImemResp_data (ImemResp_data),
        .Instr_d       (Instr_d),
        .PC_d          (PC_d),
        .PCPlus4_d     (PCPlus4_d),
        .Valid_d       (Valid_d),
        .Imem_wait     (Imem_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          vld;
        logic [31:0] instr;
        logic [31:0] pc;
    } ifid_exp_t;

    typedef struct {
        bit          vld;
        logic [31:0] addr;
        bit          busy;
    } req_exp_t;

    ifid_exp_t ifid_q[$];
    req_exp_t  req_q[$];
    ifid_exp_t pend[$];      // fetched instructions not yet in IF/ID
    ifid_exp_t cur;          // expected IF/ID contents

    int          vectors = 0;
    int          miscompares = 0;
    int          wrap_seen = 0;

    bit          out, killed, real_resp, cur_busy;
    int          cnt;
    logic [31:0] out_pc, model_pc;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'h0050_0093 ^ (a * 32'h9E37_79B1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        out      = 0;
        killed   = 0;
        cnt      = 0;
        model_pc = RST_PC;
        pend.delete();
        cur.vld   = 0;
        cur.instr = NOP;
        cur.pc    = 32'h0;
    endtask

    task automatic reset_checks();
        chk("rst_req_valid", 32'(ImemReq_valid), 32'd0);
        chk("rst_imem_wait", 32'(Imem_wait), 32'd0);
        chk("rst_valid_d", 32'(Valid_d), 32'd0);
        chk("rst_instr_d", Instr_d, NOP);
        chk("rst_pc_d", PC_d, 32'h0);
        chk("rst_pcplus4_d", PCPlus4_d, 32'h0);
        chk("rst_imem_addr", ImemAddr, RST_PC);
    endtask

    // Memory model and random control inputs for one cycle.
    task automatic drive(input bit first);
        int sel;
        Stall_f       = first ? 1'b0 : ($urandom_range(0, 3) == 0);
        Stall_d       = ($urandom_range(0, 3) == 0);
        PCSrc_e       = first ? 1'b0 : ($urandom_range(0, 12) == 0);
        sel           = $urandom_range(0, 3);
        case (sel)
            0:       PCTarget_e = 32'h0000_0100;
            1:       PCTarget_e = 32'hFFFF_FFF4;
            2:       PCTarget_e = $urandom() & 32'h0000_FFFC;
            default: PCTarget_e = 32'h0000_0000;
        endcase
        Flush_d       = PCSrc_e | (!out && ($urandom_range(0, 9) == 0));
        ImemReq_ready = ($urandom_range(0, 9) < 7);
        real_resp     = 0;
        if (out) begin
            if (cnt == 0) begin
                real_resp      = 1;
                ImemResp_valid = 1'b1;
                ImemResp_data  = instr_of(out_pc);
            end else begin
                cnt--;
                ImemResp_valid = 1'b0;
                ImemResp_data  = $urandom();
            end
        end else begin
            ImemResp_valid = first | ($urandom_range(0, 7) == 0);
            ImemResp_data  = $urandom();
        end
    endtask

    // Reference model: predicts request/IF/ID for this cycle, then advances over the edge.
    task automatic model_eval();
        ifid_exp_t e;
        req_exp_t  r;
        bit        exp_req, hs;
        ifid_q.push_back(cur);
        exp_req = !out && !Stall_f && (pend.size() == 0) && !PCSrc_e;
        r.vld   = exp_req;
        r.addr  = model_pc;
        r.busy  = out;
        req_q.push_back(r);
        cur_busy = out;
        hs = exp_req && ImemReq_ready;
        if (PCSrc_e && out) killed = 1;
        if (PCSrc_e) pend.delete();
        if (real_resp) begin
            if (!killed) begin
                e.vld   = 1;
                e.instr = instr_of(out_pc);
                e.pc    = out_pc;
                pend.push_back(e);
            end
            out = 0;
        end
        if (Flush_d) begin
            cur.vld   = 0;
            cur.instr = NOP;
        end else if (!Stall_d) begin
            if (pend.size() != 0) begin
                cur = pend.pop_front();
                if (cur.pc == 32'hFFFF_FFFC) wrap_seen++;
            end else begin
                cur.vld   = 0;
                cur.instr = NOP;
            end
        end
        if (hs) begin
            out    = 1;
            killed = 0;
            out_pc = model_pc;
            cnt    = $urandom_range(0, 2);
        end
        if (PCSrc_e)  model_pc = PCTarget_e;
        else if (hs)  model_pc = model_pc + 32'd4;
    endtask

    task automatic run_cycle(input bit release_rst);
        @(posedge clk);
        #1;
        if (release_rst) rst_n = 1'b1;
        drive(release_rst);
        @(negedge clk);
        model_eval();
    endtask

    initial begin : monitor
        req_exp_t  r;
        ifid_exp_t f;
        forever begin
            @(negedge clk);
            #2;
            while (req_q.size() != 0) begin
                r = req_q.pop_front();
                chk("req_valid", 32'(ImemReq_valid), 32'(r.vld));
                if (r.vld) chk("req_addr", ImemAddr, r.addr);
                chk("imem_wait", 32'(Imem_wait), 32'(r.busy));
            end
            while (ifid_q.size() != 0) begin
                f = ifid_q.pop_front();
                chk("valid_d", 32'(Valid_d), 32'(f.vld));
                chk("instr_d", Instr_d, f.instr);
                if (f.vld) begin
                    chk("pc_d", PC_d, f.pc);
                    chk("pcplus4_d", PCPlus4_d, f.pc + 32'd4);
                end
            end
        end
    end

    initial begin : stim
        int tries;
        rst_n          = 1'b1;
        Stall_f        = 1'b0;
        Stall_d        = 1'b0;
        Flush_d        = 1'b0;
        PCSrc_e        = 1'b0;
        PCTarget_e     = 32'h0;
        ImemReq_ready  = 1'b1;
        ImemResp_valid = 1'b1;
        ImemResp_data  = 32'hDEAD_BEEF;
        model_reset();
        #2 rst_n = 1'b0;
        #1 reset_checks();
        repeat (2) @(posedge clk);
        run_cycle(1'b1);

        for (int i = 0; i < 4000; i++) begin
            run_cycle(1'b0);
            if (i == 2000) begin
                tries = 0;
                while (!cur_busy && tries < 200) begin
                    run_cycle(1'b0);
                    tries++;
                end
                vectors++;
                if (!cur_busy) begin
                    miscompares++;
                    $display("FAIL reset_in_wait: got no outstanding request within %0d cycles, required one", tries);
                end
                #3;
                rst_n          = 1'b0;
                ImemResp_valid = 1'b1;
                ImemResp_data  = instr_of(out_pc);
                #1 reset_checks();
                model_reset();
                repeat (2) @(posedge clk);
                run_cycle(1'b1);
            end
        end

        repeat (3) @(negedge clk);
        vectors++;
        if (req_q.size() != 0 || ifid_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d unchecked entries, required 0/0", req_q.size(), ifid_q.size());
        end
        $display("wrap-around instructions delivered: %0d", wrap_seen);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Stall_f  input  1  hold the fetch PC and do not issue a new request.
REQ-005 SHALL have port Stall_d  input  1  hold the IF/ID register.
REQ-006 SHALL have port Flush_d  input  1  load a bubble into the IF/ID register.
REQ-007 SHALL have port PCSrc_e  input  1  redirect: a taken branch or jump resolved in Execute.
REQ-008 SHALL have port PCTarget_e  input  32  redirect target address.
REQ-009 SHALL have port ImemReq_valid  output  1  instruction-memory request valid.
REQ-010 SHALL have port ImemReq_ready  input  1  instruction memory accepts the request.
REQ-011 SHALL have port ImemAddr  output  32  request address (equals PC_f).
REQ-012 SHALL have port ImemResp_valid  input  1  response data valid.
REQ-013 SHALL have port ImemResp_data  input  32  fetched instruction.
REQ-014 SHALL have port Instr_d / PC_d / PCPlus4_d  output  32 each  IF/ID register contents.
REQ-015 SHALL have port Valid_d  output  1  IF/ID holds a real instruction.
REQ-016 SHALL have port Imem_wait  output  1  high while the FSM is in WAIT or DROP.

Function
REQ-017 SHALL hold PC_f, a 32-bit register; next value is PC_f+4 with carry discarded (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-018 SHALL implement FSM states REQ, WAIT and DROP, with at most one request outstanding.
REQ-019 In REQ, SHALL assert ImemReq_valid when !Stall_f, the 1-entry fetch buffer is empty and !PCSrc_e.
- On handshake (valid & ready): capture ReqPC=PC_f, set PC_f<=PC_f+4, go to WAIT.
REQ-020 In WAIT, on ImemResp_valid:
- go to REQ.
- If Stall_d=0 and the buffer is empty, bypass the response straight into IF/ID (Instr_d visible one edge after the response cycle).
- Otherwise write {data, ReqPC} into the buffer.
REQ-021 PCSrc_e=1 SHALL:
- set PC_f<=PCTarget_e and invalidate the buffer.
- Next state: DROP if a request is outstanding and no response arrives this cycle; REQ if the response arrives this cycle (response discarded).
- Redirect takes priority over Stall_f.
REQ-022 In DROP, SHALL discard the response on ImemResp_valid and go to REQ; a further PCSrc_e in DROP only updates PC_f.
REQ-023 SHALL ignore ImemResp_valid while in REQ.
REQ-024 IF/ID register priority: Flush_d|PCSrc_e > Stall_d > load.
- Flush: Instr_d=32'h0000_0013, Valid_d=0.
- Stall: hold all fields.
- Load: buffer entry (buffer emptied) or bypassed response with Valid_d=1; else bubble (NOP, Valid_d=0).
REQ-025 PCPlus4_d SHALL equal PC_d+4 (mod 2^32) whenever Valid_d=1.
REQ-026 Stall_f with no outstanding request SHALL leave PC_f, the FSM state and ImemReq_valid=0 unchanged.

Reset
REQ-027 rst_n=0 SHALL immediately force:
- PC_f=RESET_PC, FSM=REQ, buffer empty.
- Instr_d=32'h0000_0013, PC_d=0, PCPlus4_d=0, Valid_d=0.
- ImemReq_valid=0, Imem_wait=0.
REQ-028 Reset asserted with a request outstanding SHALL abandon it; a response arriving after reset release while in REQ is ignored (REQ-023).
REQ-029 The first request SHALL issue in the first clock cycle after rst_n deasserts, with ImemAddr=RESET_PC.

Verification
REQ-030 Reset release, memory always ready, 1-cycle response of 0x00500093 -> Instr_d=0x00500093, PC_d=0, Valid_d=1; next ImemAddr=0x4.
REQ-031 Response arrives while Stall_d=1 -> entry held in the buffer, no new request; Stall_d falls -> Instr_d loads the buffered entry and the request for the next PC issues.
REQ-032 PCSrc_e=1 with PCTarget_e=0x100 while in WAIT -> DROP; the stale response is discarded, next ImemAddr=0x100, Valid_d=0 in between.
REQ-033 PCSrc_e and ImemResp_valid in the same cycle -> response dropped, FSM=REQ, next ImemAddr=PCTarget_e.
REQ-034 PC_f=0xFFFF_FFFC request handshake -> next ImemAddr=0x0; PCPlus4_d=0x0 for that instruction.
REQ-035 rst_n pulsed low in WAIT -> outputs at reset values immediately; the late response is ignored; first ImemAddr=RESET_PC.
